// File: rtl/multicycle_controller.sv
// -----------------------------------------------------------------------------
// multicycle_controller
//
// Moore sequencer for a multicycle MIPS-style datapath. One shared memory, one
// ALU, and IR / A / B / ALUOut latches between states. Each state drives every
// datapath select and enable. DECODE and EXECUTE also look at opcode/funct from
// the instruction register, which holds them stable after FETCH.
//
// Optional feature (macro MULTICYCLE_JUMP_EN):
//   defined   - opcode 0x02 (j) goes to JUMP and retires in 3 cycles.
//   undefined - opcode 0x02 goes to ILLEGAL; JUMP is unreachable and
//               pc_source never reaches 2'b10.
//
// Ports:
//   clock          in   system clock, rising edge
//   clear          in   asynchronous active-high reset
//   run            in   permit to start a new instruction (sampled in FETCH)
//   opcode         in   IR[31:26]
//   funct          in   IR[5:0]
//   pc_write       out  unconditional PC load
//   pc_write_cond  out  PC load qualified by ALU zero (beq)
//   i_or_d         out  memory address select: 0 = PC, 1 = ALUOut
//   mem_read       out  shared memory read
//   mem_write      out  shared memory write
//   ir_write       out  instruction register load
//   mem_to_reg     out  write-data select: 0 = ALUOut, 1 = MDR
//   reg_dst        out  write index select: 0 = rt, 1 = rd
//   reg_write      out  register file write
//   alu_src_a      out  0 = PC, 1 = A
//   alu_src_b      out  00 = B, 01 = 4, 10 = sign-ext imm, 11 = imm<<2
//   alu_f          out  010 add, 110 sub, 000 and, 001 or, 111 slt
//   pc_source      out  00 = ALU result, 01 = ALUOut, 10 = jump target
//   state          out  current state (debug)
//   retired        out  pulse in the last state of each instruction
//   retired_count  out  retired-instruction counter, wraps
//   illegal        out  sticky unsupported-instruction flag
// -----------------------------------------------------------------------------
module multicycle_controller #(
  parameter int CNT_W = 32
) (
  input  logic             clock,
  input  logic             clear,
  input  logic             run,
  input  logic [5:0]       opcode,
  input  logic [5:0]       funct,
  output logic             pc_write,
  output logic             pc_write_cond,
  output logic             i_or_d,
  output logic             mem_read,
  output logic             mem_write,
  output logic             ir_write,
  output logic             mem_to_reg,
  output logic             reg_dst,
  output logic             reg_write,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [2:0]       alu_f,
  output logic [1:0]       pc_source,
  output logic [3:0]       state,
  output logic             retired,
  output logic [CNT_W-1:0] retired_count,
  output logic             illegal
);

  typedef enum logic [3:0] {
    S_FETCH     = 4'd0,
    S_DECODE    = 4'd1,
    S_MEM_ADDR  = 4'd2,
    S_MEM_READ  = 4'd3,
    S_MEM_WB    = 4'd4,
    S_MEM_WRITE = 4'd5,
    S_EXECUTE   = 4'd6,
    S_R_WB      = 4'd7,
    S_BRANCH    = 4'd8,
    S_ADDI_EXEC = 4'd9,
    S_ADDI_WB   = 4'd10,
    S_JUMP      = 4'd11,
    S_ILLEGAL   = 4'd12
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b111;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             rtype_ok;

  assign rtype_ok = (funct == FN_ADD) || (funct == FN_SUB) || (funct == FN_AND) ||
                    (funct == FN_OR)  || (funct == FN_SLT);

  // Next-state logic.
  always_comb begin
    // NOTE: default assignment first so every path drives state_d; no latch.
    state_d = state_q;
    case (state_q)
      S_FETCH:     state_d = run ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (opcode)
          OP_LW, OP_SW: state_d = S_MEM_ADDR;
          OP_RTYPE:     state_d = rtype_ok ? S_EXECUTE : S_ILLEGAL;
          OP_BEQ:       state_d = S_BRANCH;
          OP_ADDI:      state_d = S_ADDI_EXEC;
`ifdef MULTICYCLE_JUMP_EN
          OP_J:         state_d = S_JUMP;
`endif
          default:      state_d = S_ILLEGAL;
        endcase
      end
      S_MEM_ADDR:  state_d = (opcode == OP_SW) ? S_MEM_WRITE : S_MEM_READ;
      S_MEM_READ:  state_d = S_MEM_WB;
      S_EXECUTE:   state_d = S_R_WB;
      S_ADDI_EXEC: state_d = S_ADDI_WB;
      S_MEM_WB, S_MEM_WRITE, S_R_WB, S_ADDI_WB, S_BRANCH:
                   state_d = S_FETCH;
`ifdef MULTICYCLE_JUMP_EN
      S_JUMP:      state_d = S_FETCH;
`endif
      S_ILLEGAL:   state_d = S_ILLEGAL;  // only clear leaves
      default:     state_d = S_FETCH;
    endcase
  end

  // Moore outputs, decoded from the state register (plus run in FETCH and
  // funct in EXECUTE). A clear therefore drops reg_write/mem_write at once.
  always_comb begin
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    i_or_d        = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    mem_to_reg    = 1'b0;
    reg_dst       = 1'b0;
    reg_write     = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = 2'b00;
    alu_f         = 3'b000;
    pc_source     = 2'b00;
    retired       = 1'b0;
    illegal       = 1'b0;
    case (state_q)
      S_FETCH: begin
        if (run) begin
          mem_read  = 1'b1;
          ir_write  = 1'b1;
          pc_write  = 1'b1;
          alu_src_b = 2'b01;
          alu_f     = ALU_ADD;
        end
      end
      S_DECODE: begin
        // Speculative branch target PC + (imm<<2) into ALUOut.
        alu_src_b = 2'b11;
        alu_f     = ALU_ADD;
      end
      S_MEM_ADDR, S_ADDI_EXEC: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        alu_f     = ALU_ADD;
      end
      S_MEM_READ: begin
        mem_read = 1'b1;
        i_or_d   = 1'b1;
      end
      S_MEM_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        retired    = 1'b1;
      end
      S_MEM_WRITE: begin
        mem_write = 1'b1;
        i_or_d    = 1'b1;
        retired   = 1'b1;
      end
      S_EXECUTE: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b00;
        case (funct)
          FN_SUB:  alu_f = ALU_SUB;
          FN_AND:  alu_f = ALU_AND;
          FN_OR:   alu_f = ALU_OR;
          FN_SLT:  alu_f = ALU_SLT;
          default: alu_f = ALU_ADD;
        endcase
      end
      S_R_WB: begin
        reg_write = 1'b1;
        reg_dst   = 1'b1;
        retired   = 1'b1;
      end
      S_ADDI_WB: begin
        reg_write = 1'b1;
        retired   = 1'b1;
      end
      S_BRANCH: begin
        alu_src_a     = 1'b1;
        alu_f         = ALU_SUB;
        pc_write_cond = 1'b1;
        pc_source     = 2'b01;
        retired       = 1'b1;
      end
`ifdef MULTICYCLE_JUMP_EN
      S_JUMP: begin
        pc_write  = 1'b1;
        pc_source = 2'b10;
        retired   = 1'b1;
      end
`endif
      S_ILLEGAL: illegal = 1'b1;
      default: ;
    endcase
  end

  // Counter wraps naturally from all-ones to zero.
  assign count_d = retired ? count_q + CNT_W'(1) : count_q;

  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      state_q <= S_FETCH;
      count_q <= '0;
    end else begin
      // NOTE: non-blocking assignments for all registered state.
      state_q <= state_d;
      count_q <= count_d;
    end
  end

  assign state         = state_q;
  assign retired_count = count_q;

endmodule

// File: tb/tb_multicycle_controller.sv
module tb_multicycle_controller;

  localparam int CNT_W = 32;

  logic             clock, clear, run;
  logic [5:0]       opcode, funct;
  logic             pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write;
  logic             mem_to_reg, reg_dst, reg_write, alu_src_a;
  logic [1:0]       alu_src_b, pc_source;
  logic [2:0]       alu_f;
  logic [3:0]       state;
  logic             retired, illegal;
  logic [CNT_W-1:0] retired_count;

  multicycle_controller #(.CNT_W(CNT_W)) dut (
    .clock(clock), .clear(clear), .run(run), .opcode(opcode), .funct(funct),
    .pc_write(pc_write), .pc_write_cond(pc_write_cond), .i_or_d(i_or_d),
    .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
    .mem_to_reg(mem_to_reg), .reg_dst(reg_dst), .reg_write(reg_write),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_f(alu_f),
    .pc_source(pc_source), .state(state), .retired(retired),
    .retired_count(retired_count), .illegal(illegal)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int checks   = 0;
  int failures = 0;

  // Packed view of every control output, in a fixed order.
  logic [18:0] dut_v;
  assign dut_v = {pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
                  mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_f,
                  pc_source, retired, illegal};

  function automatic logic [18:0] cv(input logic pcw, pcwc, iord, mr, mw, irw,
                                     m2r, rd, rw, asa, input logic [1:0] asb,
                                     input logic [2:0] af, input logic [1:0] ps,
                                     input logic ret, ill);
    return {pcw, pcwc, iord, mr, mw, irw, m2r, rd, rw, asa, asb, af, ps, ret, ill};
  endfunction

  logic [18:0] v_zero, v_fetch, v_decode, v_addr, v_mrd, v_mwb, v_mwr;
  logic [18:0] v_add, v_sub, v_and, v_or, v_slt, v_rwb, v_awb, v_br, v_jmp, v_ill;

  // Per-cycle stimulus/expectation table used by each scenario.
  logic [3:0]  q_st[$];
  logic [18:0] q_v[$];
  logic        q_run[$];
  logic [5:0]  q_op[$];
  logic [5:0]  q_fn[$];

  task automatic q_reset();
    q_st.delete(); q_v.delete(); q_run.delete(); q_op.delete(); q_fn.delete();
  endtask

  task automatic push(input logic [3:0] st, input logic [18:0] v, input logic r,
                      input logic [5:0] op, input logic [5:0] fn);
    q_st.push_back(st); q_v.push_back(v); q_run.push_back(r);
    q_op.push_back(op); q_fn.push_back(fn);
  endtask

  task automatic test_reset();
    clear = 1'b1; run = 1'b0; opcode = '0; funct = '0;
    repeat (2) @(negedge clock);
    clear = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1;
      checks++;
      if (state !== 4'd0 || dut_v !== v_zero || retired_count !== '0) begin
        failures++;
        $display("FAIL reset cycle %0d: state=%0d ctrl=%b cnt=%0d, expected 0 %b 0",
                 i, state, dut_v, retired_count, v_zero);
      end
      @(negedge clock);
    end
  endtask

  task automatic test_lw();
    q_reset();
    push(4'd0, v_fetch, 1, 6'h23, 6'h00);
    push(4'd1, v_decode, 0, 6'h23, 6'h00);  // run dropped mid-instruction
    push(4'd2, v_addr, 0, 6'h23, 6'h00);
    push(4'd3, v_mrd, 0, 6'h23, 6'h00);
    push(4'd4, v_mwb, 0, 6'h23, 6'h00);
    push(4'd0, v_zero, 0, 6'h23, 6'h00);
    for (int i = 0; i < q_st.size(); i++) begin
      run = q_run[i]; opcode = q_op[i]; funct = q_fn[i];
      #1;
      checks++;
      if (state !== q_st[i] || dut_v !== q_v[i]) begin
        failures++;
        $display("FAIL lw cycle %0d: state=%0d ctrl=%b, expected state=%0d ctrl=%b",
                 i, state, dut_v, q_st[i], q_v[i]);
      end
      @(negedge clock);
    end
    checks++;
    if (retired_count !== 32'd1) begin
      failures++;
      $display("FAIL lw_count: got %0d expected 1", retired_count);
    end
  endtask

  task automatic test_slt();
    q_reset();
    push(4'd0, v_fetch, 1, 6'h00, 6'h2A);
    push(4'd1, v_decode, 0, 6'h00, 6'h2A);
    push(4'd6, v_slt, 0, 6'h00, 6'h2A);
    push(4'd7, v_rwb, 0, 6'h00, 6'h2A);
    push(4'd0, v_zero, 0, 6'h00, 6'h2A);
    for (int i = 0; i < q_st.size(); i++) begin
      run = q_run[i]; opcode = q_op[i]; funct = q_fn[i];
      #1;
      checks++;
      if (state !== q_st[i] || dut_v !== q_v[i]) begin
        failures++;
        $display("FAIL slt cycle %0d: state=%0d ctrl=%b, expected state=%0d ctrl=%b",
                 i, state, dut_v, q_st[i], q_v[i]);
      end
      @(negedge clock);
    end
    checks++;
    if (retired_count !== 32'd2) begin
      failures++;
      $display("FAIL slt_count: got %0d expected 2", retired_count);
    end
  endtask

  task automatic test_beq();
    q_reset();
    push(4'd0, v_fetch, 1, 6'h04, 6'h00);
    push(4'd1, v_decode, 0, 6'h04, 6'h00);
    push(4'd8, v_br, 0, 6'h04, 6'h00);
    push(4'd0, v_zero, 0, 6'h04, 6'h00);
    for (int i = 0; i < q_st.size(); i++) begin
      run = q_run[i]; opcode = q_op[i]; funct = q_fn[i];
      #1;
      checks++;
      if (state !== q_st[i] || dut_v !== q_v[i]) begin
        failures++;
        $display("FAIL beq cycle %0d: state=%0d ctrl=%b, expected state=%0d ctrl=%b",
                 i, state, dut_v, q_st[i], q_v[i]);
      end
      @(negedge clock);
    end
    checks++;
    if (retired_count !== 32'd3) begin
      failures++;
      $display("FAIL beq_count: got %0d expected 3", retired_count);
    end
  endtask

  // Four R-type instructions with run held high: no idle cycle between them.
  task automatic test_back_to_back();
    logic [5:0]  fns[4];
    logic [18:0] exs[4];
    fns = '{6'h20, 6'h22, 6'h24, 6'h25};
    exs = '{v_add, v_sub, v_and, v_or};
    q_reset();
    for (int k = 0; k < 4; k++) begin
      push(4'd0, v_fetch, 1, 6'h00, fns[k]);
      push(4'd1, v_decode, 1, 6'h00, fns[k]);
      push(4'd6, exs[k], 1, 6'h00, fns[k]);
      push(4'd7, v_rwb, 1, 6'h00, fns[k]);
    end
    push(4'd0, v_zero, 0, 6'h00, 6'h00);
    for (int i = 0; i < q_st.size(); i++) begin
      run = q_run[i]; opcode = q_op[i]; funct = q_fn[i];
      #1;
      checks++;
      if (state !== q_st[i] || dut_v !== q_v[i]) begin
        failures++;
        $display("FAIL b2b cycle %0d: state=%0d ctrl=%b, expected state=%0d ctrl=%b",
                 i, state, dut_v, q_st[i], q_v[i]);
      end
      @(negedge clock);
    end
    checks++;
    if (retired_count !== 32'd7) begin
      failures++;
      $display("FAIL b2b_count: got %0d expected 7", retired_count);
    end
  endtask

  task automatic test_sw_addi();
    q_reset();
    push(4'd0, v_fetch, 1, 6'h2B, 6'h00);
    push(4'd1, v_decode, 0, 6'h2B, 6'h00);
    push(4'd2, v_addr, 0, 6'h2B, 6'h00);
    push(4'd5, v_mwr, 0, 6'h2B, 6'h00);
    push(4'd0, v_fetch, 1, 6'h08, 6'h00);
    push(4'd1, v_decode, 0, 6'h08, 6'h00);
    push(4'd9, v_addr, 0, 6'h08, 6'h00);
    push(4'd10, v_awb, 0, 6'h08, 6'h00);
    push(4'd0, v_zero, 0, 6'h08, 6'h00);
    for (int i = 0; i < q_st.size(); i++) begin
      run = q_run[i]; opcode = q_op[i]; funct = q_fn[i];
      #1;
      checks++;
      if (state !== q_st[i] || dut_v !== q_v[i]) begin
        failures++;
        $display("FAIL sw_addi cycle %0d: state=%0d ctrl=%b, expected state=%0d ctrl=%b",
                 i, state, dut_v, q_st[i], q_v[i]);
      end
      @(negedge clock);
    end
    checks++;
    if (retired_count !== 32'd9) begin
      failures++;
      $display("FAIL sw_addi_count: got %0d expected 9", retired_count);
    end
  endtask

  task automatic test_jump();
    q_reset();
    push(4'd0, v_fetch, 1, 6'h02, 6'h00);
    push(4'd1, v_decode, 0, 6'h02, 6'h00);
`ifdef MULTICYCLE_JUMP_EN
    push(4'd11, v_jmp, 0, 6'h02, 6'h00);
    push(4'd0, v_zero, 0, 6'h02, 6'h00);
`else
    push(4'd12, v_ill, 0, 6'h02, 6'h00);
    push(4'd12, v_ill, 1, 6'h02, 6'h00);
`endif
    for (int i = 0; i < q_st.size(); i++) begin
      run = q_run[i]; opcode = q_op[i]; funct = q_fn[i];
      #1;
      checks++;
      if (state !== q_st[i] || dut_v !== q_v[i]) begin
        failures++;
        $display("FAIL jump cycle %0d: state=%0d ctrl=%b, expected state=%0d ctrl=%b",
                 i, state, dut_v, q_st[i], q_v[i]);
      end
      @(negedge clock);
    end
    checks++;
`ifdef MULTICYCLE_JUMP_EN
    if (retired_count !== 32'd10) begin
      failures++;
      $display("FAIL jump_count: got %0d expected 10", retired_count);
    end
`else
    if (retired_count !== 32'd9) begin
      failures++;
      $display("FAIL jump_count: got %0d expected 9", retired_count);
    end
    run = 1'b0; clear = 1'b1;
    @(negedge clock);
    clear = 1'b0;
`endif
  endtask

  task automatic test_illegal();
    // Unknown opcode: ILLEGAL is sticky for 20 cycles even with run high.
    q_reset();
    push(4'd0, v_fetch, 1, 6'h3F, 6'h00);
    push(4'd1, v_decode, 1, 6'h3F, 6'h00);
    for (int k = 0; k < 20; k++) push(4'd12, v_ill, 1, 6'h3F, 6'h00);
    // After the clear below: unsupported R-type funct.
    for (int i = 0; i < q_st.size(); i++) begin
      run = q_run[i]; opcode = q_op[i]; funct = q_fn[i];
      #1;
      checks++;
      if (state !== q_st[i] || dut_v !== q_v[i]) begin
        failures++;
        $display("FAIL illegal_op cycle %0d: state=%0d ctrl=%b, expected state=%0d ctrl=%b",
                 i, state, dut_v, q_st[i], q_v[i]);
      end
      @(negedge clock);
    end
    run = 1'b0; clear = 1'b1;
    #1;
    checks++;
    if (state !== 4'd0 || dut_v !== v_zero || retired_count !== '0) begin
      failures++;
      $display("FAIL illegal_clear: state=%0d ctrl=%b cnt=%0d, expected 0 %b 0",
               state, dut_v, retired_count, v_zero);
    end
    @(negedge clock);
    clear = 1'b0;

    q_reset();
    push(4'd0, v_fetch, 1, 6'h00, 6'h27);
    push(4'd1, v_decode, 0, 6'h00, 6'h27);
    push(4'd12, v_ill, 0, 6'h00, 6'h27);
    push(4'd12, v_ill, 0, 6'h00, 6'h27);
    for (int i = 0; i < q_st.size(); i++) begin
      run = q_run[i]; opcode = q_op[i]; funct = q_fn[i];
      #1;
      checks++;
      if (state !== q_st[i] || dut_v !== q_v[i]) begin
        failures++;
        $display("FAIL illegal_funct cycle %0d: state=%0d ctrl=%b, expected state=%0d ctrl=%b",
                 i, state, dut_v, q_st[i], q_v[i]);
      end
      @(negedge clock);
    end
    clear = 1'b1;
    #1;
    checks++;
    if (state !== 4'd0 || illegal !== 1'b0) begin
      failures++;
      $display("FAIL illegal_funct_clear: state=%0d illegal=%b, expected 0 0", state, illegal);
    end
    @(negedge clock);
    clear = 1'b0;
  endtask

  // Clear during MEM_WB: reg_write drops at once and nothing retires.
  task automatic test_clear_mid();
    q_reset();
    push(4'd0, v_fetch, 1, 6'h23, 6'h00);
    push(4'd1, v_decode, 0, 6'h23, 6'h00);
    push(4'd2, v_addr, 0, 6'h23, 6'h00);
    push(4'd3, v_mrd, 0, 6'h23, 6'h00);
    push(4'd4, v_mwb, 0, 6'h23, 6'h00);
    for (int i = 0; i < q_st.size(); i++) begin
      run = q_run[i]; opcode = q_op[i]; funct = q_fn[i];
      #1;
      checks++;
      if (state !== q_st[i] || dut_v !== q_v[i]) begin
        failures++;
        $display("FAIL clear_mid cycle %0d: state=%0d ctrl=%b, expected state=%0d ctrl=%b",
                 i, state, dut_v, q_st[i], q_v[i]);
      end
      if (i < q_st.size() - 1) @(negedge clock);
    end
    clear = 1'b1;
    #1;
    checks++;
    if (state !== 4'd0 || reg_write !== 1'b0 || dut_v !== v_zero) begin
      failures++;
      $display("FAIL clear_async: state=%0d reg_write=%b ctrl=%b, expected 0 0 %b",
               state, reg_write, dut_v, v_zero);
    end
    @(negedge clock);
    clear = 1'b0;
    @(negedge clock);
    #1;
    checks++;
    if (state !== 4'd0 || retired_count !== '0) begin
      failures++;
      $display("FAIL clear_no_retire: state=%0d cnt=%0d, expected 0 0", state, retired_count);
    end
  endtask

  initial begin
    v_zero   = '0;
    v_fetch  = cv(1,0,0,1,0,1,0,0,0,0, 2'b01, 3'b010, 2'b00, 0,0);
    v_decode = cv(0,0,0,0,0,0,0,0,0,0, 2'b11, 3'b010, 2'b00, 0,0);
    v_addr   = cv(0,0,0,0,0,0,0,0,0,1, 2'b10, 3'b010, 2'b00, 0,0);
    v_mrd    = cv(0,0,1,1,0,0,0,0,0,0, 2'b00, 3'b000, 2'b00, 0,0);
    v_mwb    = cv(0,0,0,0,0,0,1,0,1,0, 2'b00, 3'b000, 2'b00, 1,0);
    v_mwr    = cv(0,0,1,0,1,0,0,0,0,0, 2'b00, 3'b000, 2'b00, 1,0);
    v_add    = cv(0,0,0,0,0,0,0,0,0,1, 2'b00, 3'b010, 2'b00, 0,0);
    v_sub    = cv(0,0,0,0,0,0,0,0,0,1, 2'b00, 3'b110, 2'b00, 0,0);
    v_and    = cv(0,0,0,0,0,0,0,0,0,1, 2'b00, 3'b000, 2'b00, 0,0);
    v_or     = cv(0,0,0,0,0,0,0,0,0,1, 2'b00, 3'b001, 2'b00, 0,0);
    v_slt    = cv(0,0,0,0,0,0,0,0,0,1, 2'b00, 3'b111, 2'b00, 0,0);
    v_rwb    = cv(0,0,0,0,0,0,0,1,1,0, 2'b00, 3'b000, 2'b00, 1,0);
    v_awb    = cv(0,0,0,0,0,0,0,0,1,0, 2'b00, 3'b000, 2'b00, 1,0);
    v_br     = cv(0,1,0,0,0,0,0,0,0,1, 2'b00, 3'b110, 2'b01, 1,0);
    v_jmp    = cv(1,0,0,0,0,0,0,0,0,0, 2'b00, 3'b000, 2'b10, 1,0);
    v_ill    = cv(0,0,0,0,0,0,0,0,0,0, 2'b00, 3'b000, 2'b00, 0,1);

    test_reset();
    test_lw();
    test_slt();
    test_beq();
    test_back_to_back();
    test_sw_addi();
    test_jump();
    test_illegal();
    test_clear_mid();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish within 100000 time units");
    $fatal(1, "timeout");
  end

endmodule
